// File: rtl/vdic_serial_pkg.sv
// Shared types, status codes and parity helper for the serial multi-operand ALU.
package vdic_serial_pkg;

  typedef enum logic [7:0] {
    CMD_AND = 8'h01,
    CMD_OR  = 8'h02,
    CMD_XOR = 8'h04,
    CMD_ADD = 8'h10
  } operation_t;

  typedef enum logic {
    PT_DATA    = 1'b0,
    PT_CONTROL = 1'b1
  } payload_type_t;

  typedef enum logic [1:0] {
    S_RX   = 2'd0,
    S_CALC = 2'd1,
    S_TX   = 2'd2
  } state_t;

  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_INV = 8'h80;
  localparam logic [7:0] ST_OPS = 8'h40;
  localparam logic [7:0] ST_PAR = 8'h20;

  // Returns the bit that makes the total 1-count even; zero-extension does not change it.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/vdic_serial_alu_if.sv
// Serial link between a stimulus/host side (master) and the ALU (slave).
interface vdic_serial_alu_if;
  logic enable_n;
  logic din;
  logic dout;
  logic dout_valid;

  modport master (output enable_n, output din, input dout, input dout_valid);
  modport slave  (input enable_n, input din, output dout, output dout_valid);
endinterface

// File: rtl/serial_word_rx.sv
// Deserialises WORD_W-bit words (MSB first) from din; a gap in enable_n discards a partial word.
module serial_word_rx
  import vdic_serial_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 enable_n,
  input  logic                 din,
  output logic                 word_valid,
  output payload_type_t        word_type,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 parity_err
);

  localparam int WORD_W = PAYLOAD_W + 2;
  localparam int CNT_W  = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shift_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [WORD_W-1:0] word_s;

  assign word_s = {shift_r[WORD_W-2:0], din};

  // Bit collection, word completion and abort on any idle/blocked cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r    <= {WORD_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      word_valid <= 1'b0;
      word_type  <= PT_DATA;
      payload    <= {PAYLOAD_W{1'b0}};
      parity_err <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (sample_en && !enable_n) begin
        if (cnt_r == CNT_W'(WORD_W - 1)) begin
          cnt_r      <= {CNT_W{1'b0}};
          word_valid <= 1'b1;
          word_type  <= payload_type_t'(word_s[WORD_W-1]);
          payload    <= word_s[WORD_W-2:1];
          parity_err <= even_parity(64'(word_s));
        end else begin
          shift_r <= word_s;
          cnt_r   <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

endmodule

// File: rtl/vdic_serial_alu.sv
// Serial multi-operand ALU: buffers DATA operands, reduces them on a CONTROL word,
// and replies with a STATUS word followed by the result MSB/LSB words.
module vdic_serial_alu
  import vdic_serial_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int MAX_OPS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  vdic_serial_alu_if.slave   bus
);

  localparam int WORD_W = PAYLOAD_W + 2;
  localparam int RES_W  = 2 * PAYLOAD_W;
  localparam int TX_W   = 3 * WORD_W;
  localparam int CNT_W  = $clog2(MAX_OPS + 1);
  localparam int TXC_W  = $clog2(TX_W + 1);

  state_t                 state_r, state_s;
  logic [PAYLOAD_W-1:0]   buf_r [MAX_OPS];
  logic [CNT_W-1:0]       count_r;
  logic                   ovf_r, par_r;

  logic                   word_valid_s, parity_err_s, sample_en_s, go_calc_s;
  payload_type_t          word_type_s;
  logic [PAYLOAD_W-1:0]   payload_s;

  logic [RES_W-1:0]       sum_s, raw_s, result_s;
  logic [PAYLOAD_W-1:0]   and_s, or_s, xor_s, status_pad_s;
  logic                   inv_s, ops_s;
  logic [7:0]             status_s;
  logic [TX_W-1:0]        tx_word_s, tx_shift_r;
  logic [TXC_W-1:0]       tx_cnt_r;
  logic                   dout_r, dout_valid_r;

  // The cycle that accepts a CONTROL word already belongs to the computation, so din is not sampled then.
  assign go_calc_s   = word_valid_s && (word_type_s == PT_CONTROL) && !parity_err_s;
  assign sample_en_s = (state_r == S_RX) && !go_calc_s;

  serial_word_rx #(.PAYLOAD_W(PAYLOAD_W)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en_s),
    .enable_n   (bus.enable_n),
    .din        (bus.din),
    .word_valid (word_valid_s),
    .word_type  (word_type_s),
    .payload    (payload_s),
    .parity_err (parity_err_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_RX;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_RX:    state_s = go_calc_s ? S_CALC : S_RX;
      S_CALC:  state_s = S_TX;
      S_TX:    state_s = (tx_cnt_r == TXC_W'(TX_W)) ? S_RX : S_TX;
      default: state_s = S_RX;
    endcase
  end

  // Reduction over the live buffer entries plus command decode and status; the command is still held in payload_s.
  always_comb begin
    sum_s = {RES_W{1'b0}};
    and_s = {PAYLOAD_W{1'b1}};
    or_s  = {PAYLOAD_W{1'b0}};
    xor_s = {PAYLOAD_W{1'b0}};
    for (int i = 0; i < MAX_OPS; i++) begin
      sum_s = sum_s + ((CNT_W'(i) < count_r) ? RES_W'(buf_r[i]) : {RES_W{1'b0}});
      and_s = and_s & ((CNT_W'(i) < count_r) ? buf_r[i] : {PAYLOAD_W{1'b1}});
      or_s  = or_s  | ((CNT_W'(i) < count_r) ? buf_r[i] : {PAYLOAD_W{1'b0}});
      xor_s = xor_s ^ ((CNT_W'(i) < count_r) ? buf_r[i] : {PAYLOAD_W{1'b0}});
    end
    inv_s = (payload_s >> 8) != {PAYLOAD_W{1'b0}};
    raw_s = {RES_W{1'b0}};
    case (payload_s[7:0])
      CMD_ADD: raw_s = sum_s;
      CMD_AND: raw_s = RES_W'(and_s);
      CMD_OR:  raw_s = RES_W'(or_s);
      CMD_XOR: raw_s = RES_W'(xor_s);
      default: inv_s = 1'b1;
    endcase
    ops_s        = (count_r < CNT_W'(2)) || ovf_r;
    status_s     = (inv_s ? ST_INV : ST_OK) | (ops_s ? ST_OPS : ST_OK) | (par_r ? ST_PAR : ST_OK);
    result_s     = (status_s == ST_OK) ? raw_s : {RES_W{1'b0}};
    status_pad_s = PAYLOAD_W'(status_s);
    tx_word_s    = {1'b1, status_pad_s, even_parity(64'({1'b1, status_pad_s})),
                    1'b0, result_s[RES_W-1:PAYLOAD_W], even_parity(64'(result_s[RES_W-1:PAYLOAD_W])),
                    1'b0, result_s[PAYLOAD_W-1:0], even_parity(64'(result_s[PAYLOAD_W-1:0]))};
  end

  // Operand buffer and sticky flags; everything is cleared once a command has been evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OPS; i++) buf_r[i] <= {PAYLOAD_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      par_r   <= 1'b0;
    end else if (state_r == S_CALC) begin
      count_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      par_r   <= 1'b0;
    end else if ((state_r == S_RX) && word_valid_s) begin
      if (parity_err_s) begin
        par_r <= 1'b1;
      end else if (word_type_s == PT_DATA) begin
        if (count_r == CNT_W'(MAX_OPS)) begin
          ovf_r <= 1'b1;
        end else begin
          for (int i = 0; i < MAX_OPS; i++) begin
            if (CNT_W'(i) == count_r) buf_r[i] <= payload_s;
          end
          count_r <= count_r + CNT_W'(1);
        end
      end
    end
  end

  // Response serialiser: first bit leaves in the CALC cycle, then one bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_r   <= {TX_W{1'b0}};
      tx_cnt_r     <= {TXC_W{1'b0}};
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_CALC: begin
          dout_r       <= tx_word_s[TX_W-1];
          tx_shift_r   <= {tx_word_s[TX_W-2:0], 1'b0};
          tx_cnt_r     <= TXC_W'(1);
          dout_valid_r <= 1'b1;
        end
        S_TX: begin
          if (tx_cnt_r == TXC_W'(TX_W)) begin
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            tx_cnt_r     <= {TXC_W{1'b0}};
          end else begin
            dout_r     <= tx_shift_r[TX_W-1];
            tx_shift_r <= {tx_shift_r[TX_W-2:0], 1'b0};
            tx_cnt_r   <= tx_cnt_r + TXC_W'(1);
          end
        end
        default: begin
          dout_r       <= 1'b0;
          dout_valid_r <= 1'b0;
          tx_cnt_r     <= {TXC_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;

endmodule

// File: tb/tb_vdic_serial_alu.sv
// Directed bench for vdic_serial_alu (PAYLOAD_W=8, MAX_OPS=4) with a response scoreboard.
module tb_vdic_serial_alu;

  localparam int WORD_W = 10;
  localparam int TX_W   = 30;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] hi;
    logic [7:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  vdic_serial_alu_if bus ();

  vdic_serial_alu #(.PAYLOAD_W(8), .MAX_OPS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] mk_word(input logic t, input logic [7:0] p);
    return {t, p, ^{t, p}};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic t, input logic [7:0] p, input logic flip);
    logic [WORD_W-1:0] w;
    w = mk_word(t, p);
    if (flip) w[0] = ~w[0];
    for (int i = 0; i < WORD_W; i++) begin
      @(negedge clk);
      bus.enable_n = 1'b0;
      bus.din      = w[WORD_W-1-i];
    end
    @(negedge clk);
    bus.enable_n = 1'b1;
    bus.din      = 1'b0;
  endtask

  // Called at the negedge right after the last CONTROL bit was sampled (edge N).
  task automatic get_response(input string tag);
    logic [TX_W-1:0] got;
    int gaps;
    exp_t e;
    got  = '0;
    gaps = 0;
    check({tag, ":lat_n1"}, 64'(bus.dout_valid), 64'd0);
    @(negedge clk);
    check({tag, ":lat_n2"}, 64'(bus.dout_valid), 64'd0);
    @(negedge clk);
    for (int i = 0; i < TX_W; i++) begin
      if (bus.dout_valid !== 1'b1) gaps++;
      got = {got[TX_W-2:0], bus.dout};
      @(negedge clk);
    end
    check({tag, ":contig"}, 64'(gaps), 64'd0);
    check({tag, ":end_valid"}, 64'(bus.dout_valid), 64'd0);
    check({tag, ":end_dout"}, 64'(bus.dout), 64'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ":status"}, 64'(got[29:20]), 64'(mk_word(1'b1, e.status)));
      check({tag, ":msb"},    64'(got[19:10]), 64'(mk_word(1'b0, e.hi)));
      check({tag, ":lsb"},    64'(got[9:0]),   64'(mk_word(1'b0, e.lo)));
    end else begin
      check({tag, ":sb_empty"}, 64'(exp_q.size()), 64'd1);
    end
  endtask

  task automatic cmd(input string tag, input logic [7:0] op, input logic [7:0] s,
                     input logic [7:0] hi, input logic [7:0] lo);
    exp_q.push_back('{status: s, hi: hi, lo: lo});
    send_word(1'b1, op, 1'b0);
    get_response(tag);
  endtask

  task automatic data(input logic [7:0] p);
    send_word(1'b0, p, 1'b0);
  endtask

  initial begin
    int seen;
    bus.enable_n = 1'b1;
    bus.din      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", 64'(bus.dout), 64'd0);
    check("reset_valid", 64'(bus.dout_valid), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: simple add with carry into bit 7
    data(8'h7F); data(8'h01);
    cmd("t1_add", 8'h10, 8'h00, 8'h00, 8'h80);

    // 2: AND over three, then a full buffer ADD
    data(8'hFF); data(8'h0F); data(8'h3C);
    cmd("t2_and", 8'h01, 8'h00, 8'h00, 8'h0C);
    repeat (4) data(8'hFF);
    cmd("t2_add4", 8'h10, 8'h00, 8'h03, 8'hFC);

    // 3: invalid command, then the buffer must be empty
    data(8'h12); data(8'h34);
    cmd("t3_inv", 8'h55, 8'h80, 8'h00, 8'h00);
    cmd("t3_empty", 8'h10, 8'h40, 8'h00, 8'h00);

    // 4: bad-parity operand poisons the next result
    send_word(1'b0, 8'hA5, 1'b1);
    data(8'h01); data(8'h02);
    cmd("t4_par", 8'h04, 8'h20, 8'h00, 8'h00);

    // bad-parity CONTROL: no response, PAR reported on the next command
    data(8'h01);
    send_word(1'b1, 8'h10, 1'b1);
    seen = 0;
    repeat (40) begin
      if (bus.dout_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    check("badctl_silent", 64'(seen), 64'd0);
    data(8'h02);
    cmd("badctl_par", 8'h10, 8'h20, 8'h00, 8'h00);

    // 5: overflow, too few operands, aborted partial word
    repeat (5) data(8'h01);
    cmd("t5_ovf", 8'h10, 8'h40, 8'h00, 8'h00);
    data(8'h01);
    cmd("t5_one", 8'h10, 8'h40, 8'h00, 8'h00);
    data(8'h05); data(8'h06);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.enable_n = 1'b0;
      bus.din      = (i % 2 == 0) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    bus.enable_n = 1'b1;
    bus.din      = 1'b0;
    data(8'h07);
    cmd("t5_abort", 8'h10, 8'h00, 8'h00, 8'h12);

    // 6: reset in the middle of a response
    data(8'h01); data(8'h02);
    send_word(1'b1, 8'h10, 1'b0);
    repeat (2) @(negedge clk);
    repeat (12) @(negedge clk);
    check("t6_in_tx", 64'(bus.dout_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(bus.dout_valid), 64'd0);
    check("t6_rst_dout", 64'(bus.dout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_idle", 64'(bus.dout_valid), 64'd0);
    data(8'h03); data(8'h05);
    cmd("t6_or", 8'h02, 8'h00, 8'h00, 8'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
